// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: command byte, key-reader state encoding, key-to-MMU map,
// and the read-bit helper that tells which key a given READ bit belongs to.
package tm1638_pkg;

  localparam logic [7:0] CMD_READ_KEYS = 8'h42;
  localparam int         TIMER_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STB_SETUP,
    ST_CMD,
    ST_WAIT,
    ST_READ,
    ST_STB_END,
    ST_DIFF
  } state_t;

  typedef struct packed {
    logic [3:0] offset;
    logic [2:0] bitpos;
  } key_map_t;

  localparam key_map_t KEY_MAP [8] = '{
    '{4'd0, 3'd7}, '{4'd1, 3'd7}, '{4'd2, 3'd7}, '{4'd3, 3'd7},
    '{4'd4, 3'd7}, '{4'd5, 3'd7}, '{4'd6, 3'd7}, '{4'd7, 3'd7}
  };

  // Returns {valid, key}: bit0 of byte n carries key n, bit4 of byte n carries key n+4.
  function automatic logic [3:0] read_bit_key(input logic [4:0] bit_idx);
    logic [3:0] res;
    res = 4'b0000;
    if (bit_idx[2:0] == 3'd0)
      res = {1'b1, 1'b0, bit_idx[4:3]};
    else if (bit_idx[2:0] == 3'd4)
      res = {1'b1, 1'b1, bit_idx[4:3]};
    return res;
  endfunction

endpackage

// File: rtl/tm1638_bit_timer.sv
// Down-counter for TM1638 half-periods and gaps: load N, done pulses in the N-th cycle
// after the load. Shared with the display driver.
module tm1638_bit_timer
  import tm1638_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  logic [TIMER_W-1:0] cnt;
  logic               active;

  assign done = active && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_val - TIMER_W'(1);
      active <= 1'b1;
    end else if (done) begin
      active <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

endmodule

// File: rtl/tm1638_key_reader.sv
// Scans the 8 TM1638 keys with READ KEYS and emits one MMU write event per changed key.
// Optional TM1638_KEY_DEBOUNCE_EN: a change is applied only after two equal scans.
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int          CLOCK_FREQ_MHz  = 50,
  parameter int          BIT_HALF_CYCLES = CLOCK_FREQ_MHz,
  parameter int          WAIT_CYCLES     = 2 * CLOCK_FREQ_MHz,
  parameter logic [15:0] KBD_BASE_ADDR   = 16'hD00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic        o_idle,
  output logic        o_tm1638_clk,
  output logic        o_tm1638_stb,
  inout  wire         io_tm1638_data,
  output logic [7:0]  o_keys,
  output logic        kbd_write_en,
  output logic [15:0] kbd_addr,
  output logic [2:0]  kbd_bit,
  output logic        kbd_pressed
);

  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(BIT_HALF_CYCLES);
  localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(WAIT_CYCLES);

  state_t             state, state_n;
  logic               half, half_n;
  logic [4:0]         bit_idx, bit_n;
  logic [2:0]         key_idx, key_n;
  logic               tmr_load, tmr_done, sample;
  logic [TIMER_W-1:0] tmr_val;
  logic               pin_clk, pin_stb, dio_oe, dio_out, idle;
  logic               pin_clk_n, pin_stb_n, dio_oe_n, dio_out_n, idle_n;
  logic [7:0]         new_keys, keys;
  logic [3:0]         slot;
  logic               change;

  tm1638_bit_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign io_tm1638_data = dio_oe ? dio_out : 1'bz;
  assign o_tm1638_clk   = pin_clk;
  assign o_tm1638_stb   = pin_stb;
  assign o_idle         = idle;
  assign o_keys         = keys;
  assign slot           = read_bit_key(bit_idx);

`ifdef TM1638_KEY_DEBOUNCE_EN
  logic [7:0] cand;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cand <= '0;
    else if (state == ST_DIFF)
      cand[key_idx] <= new_keys[key_idx];
  end

  assign change = (state == ST_DIFF) && (new_keys[key_idx] != keys[key_idx])
                  && (new_keys[key_idx] == cand[key_idx]);
`else
  assign change = (state == ST_DIFF) && (new_keys[key_idx] != keys[key_idx]);
`endif

  assign kbd_write_en = change;
  assign kbd_addr     = change ? KBD_BASE_ADDR + {12'd0, KEY_MAP[key_idx].offset} : 16'd0;
  assign kbd_bit      = change ? KEY_MAP[key_idx].bitpos : 3'd0;
  assign kbd_pressed  = change ? new_keys[key_idx] : 1'b0;

  always_comb begin
    state_n  = state;
    half_n   = half;
    bit_n    = bit_idx;
    key_n    = key_idx;
    tmr_load = 1'b0;
    tmr_val  = HALF_LOAD;
    sample   = 1'b0;
    case (state)
      ST_IDLE:
        if (i_en) begin
          state_n  = ST_STB_SETUP;
          tmr_load = 1'b1;
        end
      ST_STB_SETUP:
        if (tmr_done) begin
          state_n  = ST_CMD;
          half_n   = 1'b0;
          bit_n    = '0;
          tmr_load = 1'b1;
        end
      ST_CMD:
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (!half) begin
            half_n = 1'b1;
          end else if (bit_idx == 5'd7) begin
            state_n = ST_WAIT;
            tmr_val = WAIT_LOAD;
          end else begin
            half_n = 1'b0;
            bit_n  = bit_idx + 5'd1;
          end
        end
      ST_WAIT:
        if (tmr_done) begin
          state_n  = ST_READ;
          half_n   = 1'b0;
          bit_n    = '0;
          tmr_load = 1'b1;
        end
      ST_READ:
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (!half) begin
            half_n = 1'b1;
            sample = 1'b1;
          end else if (bit_idx == 5'd31) begin
            state_n = ST_STB_END;
          end else begin
            half_n = 1'b0;
            bit_n  = bit_idx + 5'd1;
          end
        end
      ST_STB_END:
        if (tmr_done) begin
          state_n = ST_DIFF;
          key_n   = '0;
        end
      ST_DIFF:
        if (key_idx == 3'd7)
          state_n = ST_IDLE;
        else
          key_n = key_idx + 3'd1;
      default: state_n = ST_IDLE;
    endcase

    // Pin levels are registered from the next state so the shield never sees decode glitches.
    pin_clk_n = ((state_n == ST_CMD) || (state_n == ST_READ)) ? half_n : 1'b1;
    pin_stb_n = !((state_n == ST_STB_SETUP) || (state_n == ST_CMD) ||
                  (state_n == ST_WAIT) || (state_n == ST_READ));
    dio_oe_n  = (state_n == ST_CMD);
    dio_out_n = CMD_READ_KEYS[bit_n[2:0]];
    idle_n    = (state_n == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      half    <= 1'b0;
      bit_idx <= '0;
      key_idx <= '0;
      pin_clk <= 1'b1;
      pin_stb <= 1'b1;
      dio_oe  <= 1'b0;
      dio_out <= 1'b0;
      idle    <= 1'b1;
      keys    <= '0;
    end else begin
      state   <= state_n;
      half    <= half_n;
      bit_idx <= bit_n;
      key_idx <= key_n;
      pin_clk <= pin_clk_n;
      pin_stb <= pin_stb_n;
      dio_oe  <= dio_oe_n;
      dio_out <= dio_out_n;
      idle    <= idle_n;
      if (change)
        keys[key_idx] <= new_keys[key_idx];
    end
  end

  // DIO is sampled on the edge where CLK is driven low->high.
  always_ff @(posedge clk) begin
    if (sample && slot[3])
      new_keys[slot[2:0]] <= io_tm1638_data;
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for tm1638_key_reader: shield model on the pins, table vectors, corner sequences
// and random scans against a key-state/event reference model.
module tb_tm1638_key_reader;

  localparam int HALF     = 4;
  localparam int WAITC    = 6;
  localparam int SCAN_LEN = 82 * HALF + WAITC + 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic        o_idle, tm_clk, tm_stb;
  wire         dio;
  logic [7:0]  o_keys;
  logic        kbd_write_en, kbd_pressed;
  logic [15:0] kbd_addr;
  logic [2:0]  kbd_bit;

  int          vectors = 0;
  int          miscompares = 0;

  logic        sh_oe = 1'b0, sh_val = 1'b0;
  logic [31:0] shield_resp = '0;
  int          edge_cnt = 0;
  logic [7:0]  cmd_cap = '0;
  logic        prev_clk = 1'b1, prev_stb = 1'b1;

  logic [7:0]  mdl_keys = '0;
  logic [7:0]  mdl_cand = '0;
  logic [19:0] got_q[$];
  logic [19:0] exp_q[$];

  typedef struct {
    logic [31:0] resp;
    logic [7:0]  keys;
    int          nev;
  } vec_t;
  vec_t tbl[7];

  assign dio = sh_oe ? sh_val : 1'bz;

  tm1638_key_reader #(
    .CLOCK_FREQ_MHz  (50),
    .BIT_HALF_CYCLES (HALF),
    .WAIT_CYCLES     (WAITC),
    .KBD_BASE_ADDR   (16'hD00)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_en           (i_en),
    .o_idle         (o_idle),
    .o_tm1638_clk   (tm_clk),
    .o_tm1638_stb   (tm_stb),
    .io_tm1638_data (dio),
    .o_keys         (o_keys),
    .kbd_write_en   (kbd_write_en),
    .kbd_addr       (kbd_addr),
    .kbd_bit        (kbd_bit),
    .kbd_pressed    (kbd_pressed)
  );

  always #5 clk = ~clk;

  // Shield: captures the command on CLK rises, presents key bits on CLK falls after it.
  always @(tm_clk or tm_stb) begin
    if (!tm_stb && prev_stb) begin
      edge_cnt = 0;
      cmd_cap  = '0;
    end
    if (tm_stb) begin
      sh_oe = 1'b0;
    end else if (tm_clk && !prev_clk) begin
      if (edge_cnt < 8) cmd_cap[edge_cnt[2:0]] = dio;
      edge_cnt++;
    end else if (!tm_clk && prev_clk && edge_cnt >= 8 && edge_cnt < 40) begin
      sh_oe  = 1'b1;
      sh_val = shield_resp[edge_cnt - 8];
    end
    prev_clk = tm_clk;
    prev_stb = tm_stb;
  end

  always @(negedge clk)
    if (kbd_write_en) got_q.push_back({kbd_addr, kbd_bit, kbd_pressed});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_scan(input logic [31:0] resp);
    logic nb, apply;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      nb = (k < 4) ? resp[8 * k] : resp[8 * (k - 4) + 4];
      apply = (nb != mdl_keys[k]);
`ifdef TM1638_KEY_DEBOUNCE_EN
      apply = apply && (nb == mdl_cand[k]);
      mdl_cand[k] = nb;
`endif
      if (apply) begin
        exp_q.push_back({16'hD00 + 16'(k), 3'd7, nb});
        mdl_keys[k] = nb;
      end
    end
  endtask

  // Called at a negedge; i_en goes high immediately so consecutive calls are back-to-back.
  task automatic do_scan(input logic [31:0] resp, input int poke_at);
    int cnt;
    bit poked;
    shield_resp = resp;
    got_q.delete();
    model_scan(resp);
    i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    cnt = 0;
    poked = 0;
    while (!o_idle && cnt < 4 * SCAN_LEN) begin
      if (poke_at > 0 && !poked && edge_cnt >= poke_at) begin
        i_en = 1'b1;
        poked = 1;
      end else begin
        i_en = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    i_en = 1'b0;
    check("cmd_byte", {24'd0, cmd_cap}, 32'h42);
    check("clk_rises_stb_low", 32'(edge_cnt), 32'd40);
    check("scan_len", 32'(cnt), 32'(SCAN_LEN));
    check("keys", {24'd0, o_keys}, {24'd0, mdl_keys});
    check("event_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("event", {12'd0, got_q[i]}, {12'd0, exp_q[i]});
  endtask

  initial begin
    int wcnt;
    tbl[0] = '{32'h0010_0001, 8'h41, 2};
    tbl[1] = '{32'h0000_0000, 8'h00, 2};
    tbl[2] = '{32'h0000_0000, 8'h00, 0};
    tbl[3] = '{32'hEEEE_EEEE, 8'h00, 0};
    tbl[4] = '{32'h1111_1111, 8'hFF, 8};
    tbl[5] = '{32'h0101_0101, 8'h0F, 4};
    tbl[6] = '{32'h1010_1010, 8'hF0, 8};

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_stb", {31'd0, tm_stb}, 32'd1);
    check("rst_clk", {31'd0, tm_clk}, 32'd1);
    check("rst_idle", {31'd0, o_idle}, 32'd1);
    check("rst_keys", {24'd0, o_keys}, 32'd0);
    check("rst_event", {12'd0, kbd_write_en, kbd_addr, kbd_bit, kbd_pressed}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_scan(tbl[i].resp, 0);
`ifndef TM1638_KEY_DEBOUNCE_EN
      check("tbl_keys", {24'd0, o_keys}, {24'd0, tbl[i].keys});
      check("tbl_nev", 32'(got_q.size()), 32'(tbl[i].nev));
      if (i == 0 && got_q.size() == 2) begin
        check("press_k0", {12'd0, got_q[0]}, {12'd0, 16'h0D00, 3'd7, 1'b1});
        check("press_k6", {12'd0, got_q[1]}, {12'd0, 16'h0D06, 3'd7, 1'b1});
      end
`endif
    end

`ifdef TM1638_KEY_DEBOUNCE_EN
    do_scan(32'h0, 0);
    do_scan(32'h0, 0);
    do_scan(32'h1, 0);
    check("db_single_nev", 32'(got_q.size()), 32'd0);
    do_scan(32'h0, 0);
    check("db_glitch_nev", 32'(got_q.size()), 32'd0);
    do_scan(32'h1, 0);
    do_scan(32'h1, 0);
    check("db_stable_nev", 32'(got_q.size()), 32'd1);
`endif

    // i_en during READ must be ignored.
    do_scan(32'h0000_1000, 20);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("busy_ignored_idle", {31'd0, o_idle}, 32'd1);

    // Abort mid-READ with keys set.
    do_scan(32'h1111_1111, 0);
    do_scan(32'h1111_1111, 0);
    got_q.delete();
    i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    wcnt = 0;
    while (edge_cnt < 24 && wcnt < 4 * SCAN_LEN) begin
      wcnt++;
      @(negedge clk);
    end
    check("abort_reached_read", {31'd0, (edge_cnt >= 24)}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_stb", {31'd0, tm_stb}, 32'd1);
    check("abort_clk", {31'd0, tm_clk}, 32'd1);
    check("abort_keys", {24'd0, o_keys}, 32'd0);
    check("abort_idle", {31'd0, o_idle}, 32'd1);
    rst_n = 1'b1;
    mdl_keys = '0;
    mdl_cand = '0;
    repeat (SCAN_LEN + 20) @(negedge clk);
    check("abort_no_events", 32'(got_q.size()), 32'd0);

    for (int i = 0; i < 12; i++)
      do_scan($urandom, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
